// File: rtl/multicycle_control_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with a req/ack memory timeout.
// Optional performance counters are enabled with `define CTRL_PERF_COUNTER_EN.
module multicycle_control_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic [5:0]       io_opcode,
    input  logic             io_memAck,
    output logic             io_memRead,
    output logic             io_memWrite,
    output logic             io_iorD,
    output logic             io_irWrite,
    output logic             io_pcWrite,
    output logic             io_pcWriteC,
    output logic             io_pcSrc,
    output logic [3:0]       io_aluOp,
    output logic             io_aluSrcB,
    output logic             io_regWrite,
    output logic             io_memToReg,
    output logic             io_illegal,
    output logic             io_halted,
    output logic             io_error
`ifdef CTRL_PERF_COUNTER_EN
    ,
    output logic [CNT_W-1:0] io_instrCount,
    output logic [CNT_W-1:0] io_cycleCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic op_alu, op_mem, op_store, op_jump, op_branch, op_halt, op_illegal;
    logic tmo_last;

    assign op_alu     = ~io_opcode[5];
    assign op_mem     = (io_opcode[5:4] == 2'b10);
    assign op_store   = io_opcode[0];
    assign op_jump    = (io_opcode == 6'b110000);
    assign op_branch  = (io_opcode == 6'b110001);
    assign op_halt    = (io_opcode == 6'b111111);
    assign op_illegal = (io_opcode[5:4] == 2'b11) & ~op_jump & ~op_branch & ~op_halt;
    assign tmo_last   = (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE:   if (io_start) state_d = S_FETCH;
            S_FETCH: begin
                if (io_memAck) begin
                    state_d = S_DECODE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_last) state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (op_halt)         state_d = S_HALT;
                else if (op_illegal) state_d = S_FETCH;
                else                 state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_alu)      state_d = S_WB;
                else if (op_mem) state_d = S_MEM;
                else             state_d = S_FETCH;
            end
            S_MEM: begin
                if (io_memAck) begin
                    state_d = op_store ? S_FETCH : S_WB;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_last) state_d = S_ERR;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_IDLE;
        endcase
        // Every fresh entry into a request phase starts its wait budget from zero.
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q)
            tmo_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Strobes are forced low during the reset cycle so an aborted instruction cannot leak one.
    always_comb begin
        io_memRead  = 1'b0;
        io_memWrite = 1'b0;
        io_iorD     = 1'b0;
        io_irWrite  = 1'b0;
        io_pcWrite  = 1'b0;
        io_pcWriteC = 1'b0;
        io_pcSrc    = 1'b0;
        io_aluOp    = 4'h0;
        io_aluSrcB  = 1'b0;
        io_regWrite = 1'b0;
        io_memToReg = 1'b0;
        io_illegal  = 1'b0;
        io_halted   = 1'b0;
        io_error    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    io_memRead = 1'b1;
                    io_irWrite = io_memAck;
                    io_pcWrite = io_memAck;
                end
                S_DECODE: io_illegal = op_illegal;
                S_EXEC: begin
                    if (op_alu) begin
                        io_aluOp   = io_opcode[3:0];
                        io_aluSrcB = io_opcode[4];
                    end else if (op_mem) begin
                        io_aluSrcB = 1'b1;
                    end else if (op_jump) begin
                        io_pcWrite = 1'b1;
                        io_pcSrc   = 1'b1;
                    end else if (op_branch) begin
                        io_pcWriteC = 1'b1;
                        io_pcSrc    = 1'b1;
                        io_aluOp    = 4'h1;
                    end
                end
                S_MEM: begin
                    io_iorD     = 1'b1;
                    io_memRead  = ~op_store;
                    io_memWrite = op_store;
                end
                S_WB: begin
                    io_regWrite = 1'b1;
                    io_memToReg = op_mem & ~op_store;
                end
                S_HALT:  io_halted = 1'b1;
                S_ERR:   io_error  = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_COUNTER_EN
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (state_q == S_DECODE && !op_halt && instr_cnt_q != '1)
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        if (state_q != S_IDLE && state_q != S_HALT && state_q != S_ERR && cycle_cnt_q != '1)
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign io_instrCount = reset ? '0 : instr_cnt_q;
    assign io_cycleCount = reset ? '0 : cycle_cnt_q;
`endif

endmodule
